// File: rtl/audioport_pkg.sv
// rtl/audioport_pkg.sv - shared constants and sample type for the audio port
package audioport_pkg;

    localparam int AUDIO_FIFO_DEPTH         = 8;
    localparam int AUDIO_FIFO_LOW_WATERMARK = 2;
    localparam int AUDIO_FIFO_LEVEL_W       = $clog2(AUDIO_FIFO_DEPTH) + 1;
    localparam int AUDIO_SAMPLE_W           = 24;

    typedef struct packed {
        logic [AUDIO_SAMPLE_W-1:0] left;
        logic [AUDIO_SAMPLE_W-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/audio_fifo_mem.sv
// rtl/audio_fifo_mem.sv - stereo register array, synchronous write, combinational read
module audio_fifo_mem
    import audioport_pkg::*;
#(
    parameter int DEPTH = AUDIO_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  stereo_sample_t wdata,
    input  logic [AW-1:0]  raddr,
    output stereo_sample_t rdata
);

    stereo_sample_t mem [DEPTH];

    // Cleared on reset so a stale entry can never reach the serializer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/audio_fifo_unit.sv
// rtl/audio_fifo_unit.sv - stereo FIFO feeding the I2S serializer (option: AUDIO_FIFO_HOLD_LAST_EN)
module audio_fifo_unit
    import audioport_pkg::*;
#(
    parameter int FIFO_DEPTH    = AUDIO_FIFO_DEPTH,
    parameter int LOW_WATERMARK = AUDIO_FIFO_LOW_WATERMARK,
    localparam int AW           = $clog2(FIFO_DEPTH),
    localparam int LVW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            play_in,
    input  logic            cfg_in,
    input  logic            push_in,
    input  logic [23:0]     audio0_in,
    input  logic [23:0]     audio1_in,
    input  logic            req_in,
    output logic [23:0]     audio0_out,
    output logic [23:0]     audio1_out,
    output logic [LVW-1:0]  level_out,
    output logic            full_out,
    output logic            empty_out,
    output logic            refill_out,
    output logic            overflow_out,
    output logic            underflow_out
);

    localparam logic [LVW-1:0] DEPTH_L = LVW'(FIFO_DEPTH);
    localparam logic [LVW-1:0] LOW_L   = LVW'(LOW_WATERMARK);

    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           play_q;
    logic           flush;
    logic           pop_ok;
    logic           push_ok;
    logic           pop_empty;
    logic           push_drop;
    logic [LVW-1:0] level_next;
    stereo_sample_t rdata;
    stereo_sample_t wdata;

    assign wdata.left  = audio0_in;
    assign wdata.right = audio1_in;

    audio_fifo_mem #(.DEPTH(FIFO_DEPTH)) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push_ok),
        .waddr (wptr),
        .wdata (wdata),
        .raddr (rptr),
        .rdata (rdata)
    );

    // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
    always_comb begin
        flush      = cfg_in | (play_q & ~play_in);
        pop_ok     = req_in & play_in & ~empty_out & ~flush;
        pop_empty  = req_in & play_in & empty_out & ~flush;
        push_ok    = push_in & (~full_out | pop_ok) & ~flush;
        push_drop  = push_in & ~push_ok & ~flush;
        level_next = level_out;
        if (flush) begin
            level_next = '0;
        end else if (push_ok && !pop_ok) begin
            level_next = level_out + LVW'(1);
        end else if (pop_ok && !push_ok) begin
            level_next = level_out - LVW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr          <= '0;
            rptr          <= '0;
            play_q        <= 1'b0;
            level_out     <= '0;
            full_out      <= 1'b0;
            empty_out     <= 1'b1;
            refill_out    <= 1'b0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
            audio0_out    <= '0;
            audio1_out    <= '0;
        end else begin
            play_q        <= play_in;
            overflow_out  <= push_drop;
            underflow_out <= pop_empty;
            level_out     <= level_next;
            full_out      <= (level_next == DEPTH_L);
            empty_out     <= (level_next == '0);
            refill_out    <= play_in && (level_next <= LOW_L);
            if (flush) begin
                wptr       <= '0;
                rptr       <= '0;
                audio0_out <= '0;
                audio1_out <= '0;
            end else begin
                if (push_ok) begin
                    wptr <= wptr + AW'(1);
                end
                if (pop_ok) begin
                    rptr       <= rptr + AW'(1);
                    audio0_out <= rdata.left;
                    audio1_out <= rdata.right;
                end else if (pop_empty) begin
`ifdef AUDIO_FIFO_HOLD_LAST_EN
                    audio0_out <= audio0_out;
                    audio1_out <= audio1_out;
`else
                    audio0_out <= '0;
                    audio1_out <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_fifo_unit.sv
// tb/tb_audio_fifo_unit.sv - scoreboard bench for audio_fifo_unit
module tb_audio_fifo_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        play_in, cfg_in, push_in, req_in;
    logic [23:0] audio0_in, audio1_in;
    logic [23:0] audio0_out, audio1_out;
    logic [3:0]  level_out;
    logic        full_out, empty_out, refill_out, overflow_out, underflow_out;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        u;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

`ifdef AUDIO_FIFO_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    audio_fifo_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .play_in       (play_in),
        .cfg_in        (cfg_in),
        .push_in       (push_in),
        .audio0_in     (audio0_in),
        .audio1_in     (audio1_in),
        .req_in        (req_in),
        .audio0_out    (audio0_out),
        .audio1_out    (audio1_out),
        .level_out     (level_out),
        .full_out      (full_out),
        .empty_out     (empty_out),
        .refill_out    (refill_out),
        .overflow_out  (overflow_out),
        .underflow_out (underflow_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted request is answered one clock later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst_n && req_in && play_in && !cfg_in) begin
                #1;
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_left", {8'h0, audio0_out}, {8'h0, e.l});
                    chk("pop_right", {8'h0, audio1_out}, {8'h0, e.r});
                    chk("pop_underflow", {31'h0, underflow_out}, {31'h0, e.u});
                end
            end
        end
    end

    task automatic cyc(input logic p, input logic [23:0] a, input logic [23:0] b,
                       input logic r, input logic c,
                       input logic [23:0] el, input logic [23:0] er, input logic eu);
        exp_t e;
        push_in = p; audio0_in = a; audio1_in = b; req_in = r; cfg_in = c;
        if (r && play_in && !c) begin
            e.l = el; e.r = er; e.u = eu;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        push_in = 1'b0; req_in = 1'b0; cfg_in = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 24'h0, 24'h0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
    endtask

    task automatic push_k(input logic [23:0] k);
        cyc(1'b1, k, k | 24'h800000, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
    endtask

    task automatic pop_k(input logic [23:0] k);
        cyc(1'b0, 24'h0, 24'h0, 1'b1, 1'b0, k, k | 24'h800000, 1'b0);
    endtask

    task automatic chk_status(input string name, input int lvl, input logic f,
                              input logic em, input logic rf);
        chk({name, "_level"}, {28'h0, level_out}, lvl);
        chk({name, "_full"}, {31'h0, full_out}, {31'h0, f});
        chk({name, "_empty"}, {31'h0, empty_out}, {31'h0, em});
        chk({name, "_refill"}, {31'h0, refill_out}, {31'h0, rf});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] ul, ur;
        rst_n = 1'b0; play_in = 1'b1; cfg_in = 1'b0; push_in = 1'b0; req_in = 1'b0;
        audio0_in = '0; audio1_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_status("reset", 0, 1'b0, 1'b1, 1'b0);
        chk("reset_audio0", {8'h0, audio0_out}, 32'h0);
        chk("reset_ovf", {31'h0, overflow_out}, 32'h0);
        chk("reset_unf", {31'h0, underflow_out}, 32'h0);
        rst_n = 1'b1;
        idle();
        chk_status("idle_play", 0, 1'b0, 1'b1, 1'b1);

        // Basic push/pop ordering
        for (int k = 1; k <= 4; k++) push_k(24'(k));
        chk_status("four_pushed", 4, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) pop_k(24'(k));
        chk_status("four_popped", 0, 1'b0, 1'b1, 1'b1);

        // Overflow on the ninth push
        for (int k = 1; k <= 8; k++) push_k(24'(k));
        chk_status("eight_pushed", 8, 1'b1, 1'b0, 1'b0);
        chk("no_ovf_8th", {31'h0, overflow_out}, 32'h0);
        push_k(24'h9);
        chk("ovf_9th", {31'h0, overflow_out}, 32'h1);
        chk_status("after_ovf", 8, 1'b1, 1'b0, 1'b0);
        idle();
        chk("ovf_single", {31'h0, overflow_out}, 32'h0);
        for (int k = 1; k <= 8; k++) pop_k(24'(k));
        chk_status("drained", 0, 1'b0, 1'b1, 1'b1);

        // Underflow after a known sample
        cyc(1'b1, 24'h123456, 24'h654321, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
        cyc(1'b0, 24'h0, 24'h0, 1'b1, 1'b0, 24'h123456, 24'h654321, 1'b0);
        ul = HOLD ? 24'h123456 : 24'h0;
        ur = HOLD ? 24'h654321 : 24'h0;
        cyc(1'b0, 24'h0, 24'h0, 1'b1, 1'b0, ul, ur, 1'b1);
        chk_status("underflow", 0, 1'b0, 1'b1, 1'b1);
        idle();
        chk("unf_single", {31'h0, underflow_out}, 32'h0);

        // Full with simultaneous push and pop
        for (int k = 8'h21; k <= 8'h28; k++) push_k(24'(k));
        cyc(1'b1, 24'h29, 24'h800029, 1'b1, 1'b0, 24'h21, 24'h800021, 1'b0);
        chk_status("full_both", 8, 1'b1, 1'b0, 1'b0);
        chk("full_both_ovf", {31'h0, overflow_out}, 32'h0);
        for (int k = 8'h22; k <= 8'h29; k++) pop_k(24'(k));
        chk_status("full_both_drain", 0, 1'b0, 1'b1, 1'b1);

        // Empty with simultaneous push and pop: no bypass
        ul = HOLD ? 24'h29 : 24'h0;
        ur = HOLD ? 24'h800029 : 24'h0;
        cyc(1'b1, 24'h31, 24'h800031, 1'b1, 1'b0, ul, ur, 1'b1);
        chk_status("empty_both", 1, 1'b0, 1'b0, 1'b1);
        pop_k(24'h31);

        // cfg flush at level 5
        for (int k = 8'h41; k <= 8'h45; k++) push_k(24'(k));
        chk_status("level5", 5, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 24'h46, 24'h800046, 1'b0, 1'b1, 24'h0, 24'h0, 1'b0);
        chk_status("cfg_flush", 0, 1'b0, 1'b1, 1'b1);
        chk("cfg_audio0", {8'h0, audio0_out}, 32'h0);
        chk("cfg_audio1", {8'h0, audio1_out}, 32'h0);
        chk("cfg_no_ovf", {31'h0, overflow_out}, 32'h0);

        // play_in falling at level 3
        for (int k = 8'h51; k <= 8'h53; k++) push_k(24'(k));
        pop_k(24'h51);
        push_k(24'h54);
        chk_status("level3", 3, 1'b0, 1'b0, 1'b0);
        play_in = 1'b0;
        idle();
        chk_status("fell_flush", 0, 1'b0, 1'b1, 1'b0);
        chk("fell_audio0", {8'h0, audio0_out}, 32'h0);
        chk("fell_audio1", {8'h0, audio1_out}, 32'h0);
        push_k(24'h61);
        cyc(1'b0, 24'h0, 24'h0, 1'b1, 1'b0, 24'h0, 24'h0, 1'b0);
        chk_status("req_no_play", 1, 1'b0, 1'b0, 1'b0);
        chk("req_no_play_audio", {8'h0, audio0_out}, 32'h0);
        chk("req_no_play_unf", {31'h0, underflow_out}, 32'h0);
        play_in = 1'b1;
        pop_k(24'h61);

        // Asynchronous reset at level 6
        for (int k = 8'h71; k <= 8'h76; k++) push_k(24'(k));
        pop_k(24'h71);
        push_k(24'h77);
        chk_status("level6", 6, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk_status("async_reset", 0, 1'b0, 1'b1, 1'b0);
        chk("async_audio0", {8'h0, audio0_out}, 32'h0);
        chk("async_audio1", {8'h0, audio1_out}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();
        push_k(24'h81);
        pop_k(24'h81);
        idle();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/audio_fifo_unit.md
Name: audio_fifo_unit

Overview:
- Stereo sample buffer directly upstream of the I2S serializer.
- Accepts 24-bit left/right sample pairs from the DSP/filter stage and holds them in a small FIFO.
- On each one-cycle request pulse from the serializer it pops a pair onto its registered outputs, which drive the serializer's audio0_in/audio1_in.
- Reports fill level, overflow/underflow events and a low-watermark refill request to the upstream stage.

Parameters:
- FIFO_DEPTH, 8: number of stereo pairs stored; power of two, at least 4.
- LOW_WATERMARK, 2: when level is at or below this value, refill_out is high.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- play_in  in  1  playback enable, same signal the serializer sees
- cfg_in  in  1  one-cycle configuration pulse; flushes the FIFO
- push_in  in  1  write strobe from the upstream stage
- audio0_in  in  24  left sample to write
- audio1_in  in  24  right sample to write
- req_in  in  1  one-cycle pop request (serializer req_out)
- audio0_out  out  24  registered left sample to the serializer
- audio1_out  out  24  registered right sample to the serializer
- level_out  out  $clog2(FIFO_DEPTH)+1  current fill count
- full_out  out  1  level == FIFO_DEPTH
- empty_out  out  1  level == 0
- refill_out  out  1  play_in && level <= LOW_WATERMARK
- overflow_out  out  1  one-cycle pulse: push dropped
- underflow_out  out  1  one-cycle pulse: pop on empty

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n); all flops clear on rst_n low.
- Reset values:
  - audio*_out = 0, level_out = 0, empty_out = 1.
  - full_out, refill_out, overflow_out and underflow_out = 0.
  - Read and write pointers = 0.
- Storage: two 24-bit arrays (or one 48-bit array) of FIFO_DEPTH entries.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - Level is tracked in a separate counter; full/empty are derived from the counter, never from pointer equality.
- Push: on push_in && !full, write the pair at wptr, then wptr+1 and level+1.
  - push_in while full: data dropped, state unchanged, overflow_out = 1 in the next cycle.
- Pop: on req_in && play_in && !empty, register mem[rptr] into audio*_out, then rptr+1 and level-1.
  - Latency: outputs change exactly one clock after the req_in cycle, which puts them in place before the serializer's next sck fall.
  - req_in && play_in && empty: outputs forced to 0, underflow_out = 1 in the next cycle, pointers and level unchanged.
- req_in while play_in is low is ignored.
- Simultaneous push and pop:
  - Non-empty and non-full: both happen, level unchanged.
  - Full: both happen and the push is accepted, level stays at FIFO_DEPTH.
  - Empty: no bypass; the pop underflows and the push is written, level becomes 1.
- Flush: cfg_in high, or play_in falling (sampled $fell), resets pointers and level to 0 and audio*_out to 0 in the next cycle.
  - Any push in the flush cycle is discarded, with no overflow pulse.
  - A flush takes priority over push and pop in the same cycle.
- Status outputs: level_out, full_out, empty_out and refill_out are registered, consistent with the post-update counter, and never X after reset.
- Reset mid-operation: immediate return to the reset values; no partial write survives.

Optional Feature:
- Macro: AUDIO_FIFO_HOLD_LAST_EN.
- Defined: on underflow, audio*_out keep their last popped values instead of going to 0 (avoids a click on a DAC glitch). A flush still zeroes them. underflow_out pulses unchanged.
- Undefined: underflow drives zeros, as specified above.

Decomposition:
- Shared package audioport_pkg holds:
  - AUDIO_FIFO_DEPTH and AUDIO_FIFO_LOW_WATERMARK constants, used as the parameter defaults.
  - A stereo_sample_t packed struct {logic [23:0] left, right;}.
  - A level width constant.
- One natural sub-module, audio_fifo_mem: a parameterised dual-pointer register array with a synchronous write port and a combinational read port.
- Control, counters, flush and status logic stay in audio_fifo_unit.

Test Plan:
- Reset, then push pairs (0x000001, 0x800001) to (0x000004, 0x800004) with play_in high: level_out = 4, refill_out = 0. Four req_in pulses give audio0_out = 1, 2, 3, 4, each one cycle after its req, then empty_out = 1 and refill_out = 1.
- Push 9 pairs into a depth-8 FIFO: full_out = 1 after the 8th push, overflow_out pulses once on the 9th, and pops return pairs 1 to 8 only.
- req_in on an empty FIFO after audio0_out = 0x123456: underflow_out pulses, audio0_out = 0 (or 0x123456 with AUDIO_FIFO_HOLD_LAST_EN), level_out stays 0.
- Full FIFO with push_in and req_in in the same cycle: level_out stays 8, the oldest pair is output, the new pair is read out 8 pops later. Empty FIFO with both in one cycle: underflow pulse and level_out = 1.
- Level 5: a cfg_in pulse gives level_out = 0 and audio*_out = 0 next cycle. A separate run with play_in dropping at level 3 gives the same flush, and req_in is ignored while play_in is low.
- Assert rst_n low mid-stream at level 6: all outputs reach reset values asynchronously, before the next clk edge.
